ahb_spi_fifo_master: RTL and testbench
======================================

# ahb_spi_fifo_master

AHB-Lite slave SPI master, parametrised successor of the single-word SPI peripheral. It adds TX/RX byte FIFOs, a programmable SCLK divider, all four CPOL/CPHA modes and a parametrised slave-select vector. It sits on the AHB bus behind the decoder, and software streams bytes without polling per transfer.

## Interface
- SS_WIDTH, 8: number of slave-select outputs (1..32).
- FIFO_DEPTH, 8: entries per TX and RX FIFO; power of two, 2..64.
- DIV_WIDTH, 8: width of the SCLK divider field (≤8).
- HCLK  in  1  sole clock.
- HRESETn  in  1  reset; synchronous, active-low.
- HSEL, HREADY, HWRITE  in  1  AHB-Lite control.
- HADDR  in  32  address; only [7:0] decoded.
- HSIZE  in  3; HTRANS  in  2; HWDATA  in  32.
- HRDATA  out  32  read data; 0 in reset.
- HREADYOUT  out  1  tied 1 (zero wait states).
- SPI_MISO_i  in  1  serial in.
- SPI_MOSI_o  out  1  serial out; 0 in reset.
- SPI_CLK_o  out  1  SCLK; reset 0, idles at CPOL.
- SPI_SS_o  out  SS_WIDTH  selects; reset all 1.
- IRQ_o  out  1  interrupt; present only with AHB_SPI_IRQ_EN; reset 0.

## Operation
- Address phase is captured when HREADY=1; the write/read strobe is HSEL & HTRANS[1] & HWRITE, or its read counterpart. Register update and FIFO push/pop happen in the data phase.
- 0x00 CTRL (RW, reset 0): [0] EN, [1] CPOL, [2] CPHA, [3] SS_ACTIVE_HIGH, [8 +: DIV_WIDTH] CLKDIV.
- 0x04 STATUS (RO, except W1C bits):
  - [0] BUSY, [1] TX_FULL, [2] TX_EMPTY, [3] RX_FULL, [4] RX_EMPTY.
  - [5] RX_OVF and [6] TX_OVF are sticky; writing 1 clears.
  - [15:8] TX level, [23:16] RX level.
- 0x08 SS (RW, reset 0): bit=1 selects the slave. SPI_SS_o = SS_ACTIVE_HIGH ? SS : ~SS. Software owns SS; the engine never toggles it.
- 0x0C TXDATA (WO): HWDATA[7:0] is pushed. A push while full is dropped and sets TX_OVF.
- 0x10 RXDATA (RO): returns {24'b0, head} and pops. A read while empty returns 0, does not pop and sets no flag.
- Other offsets read 0; writes to them are ignored.
- Engine FSM: IDLE → LOAD → SHIFT → DONE → IDLE/LOAD.
  - IDLE → LOAD when EN=1 and TX not empty.
  - LOAD pops TX and latches CPOL, CPHA and CLKDIV.
  - SHIFT runs 16 half-periods, each CLKDIV+1 HCLK cycles. Bits go MSB first.
  - CPHA=0: MOSI is driven in LOAD; sample on leading edge, shift on trailing edge.
  - CPHA=1: shift on leading edge, sample on trailing edge.
  - DONE pushes the received byte to RX. If RX is full, the byte is discarded and RX_OVF is set. DONE then goes to LOAD if EN=1 and TX is non-empty, otherwise to IDLE.
- BUSY = state≠IDLE or TX not empty while EN=1.
- Clearing EN mid-byte: the current byte completes and no further pop occurs.
- CTRL writes while BUSY take effect at the next LOAD.
- Simultaneous push and pop on one FIFO leaves its level unchanged. Push-when-full and pop-when-empty are suppressed.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs equal.

## Timing
- HRDATA is valid in the data phase, combinational from the registered address and register state. HREADYOUT is always 1.
- TXDATA write in cycle N: the FIFO holds the byte at N+1, and LOAD can occur at N+2 if IDLE with EN=1.
- Byte time = 1 (LOAD) + 16·(CLKDIV+1) + 1 (DONE) cycles. Back-to-back bytes add no further gap.
- The RX level increments the cycle after DONE.
- STATUS reflects FIFO state one cycle after a push or pop.
- Reset mid-transfer: at the next HCLK edge all state returns to reset values. SCLK=0, MOSI=0, FIFOs empty, sticky flags clear.

## Configuration
- AHB_SPI_IRQ_EN defined:
  - Adds IRQ_o and 0x14 IRQ_MASK (RW, reset 0): [0] RX not empty, [1] TX empty, [2] RX_OVF, [3] TX_OVF.
  - IRQ_o is registered: |(mask & sources), one cycle after a source change.
- AHB_SPI_IRQ_EN undefined: no IRQ_o port, and 0x14 reads 0.

## Structure
- Shared package holds:
  - register offsets,
  - CTRL/STATUS bit indices,
  - FSM state enum (IDLE, LOAD, SHIFT, DONE),
  - IRQ source indices.
- Sub-module spi_shift_engine contains the FSM, divider, shift register and SCLK/MOSI generation, with a pop/push handshake to the FIFOs. The FIFOs and AHB decode stay in the top level.

## Test plan
- Mode 0, CLKDIV=1, MISO loopback to MOSI: push 0xA5, 0x3C → RX pops 0xA5 then 0x3C; each byte takes 34 cycles; SCLK idles at 0.
- Mode 3 (CPOL=1, CPHA=1), CLKDIV=0: push 0x81 → SCLK idles at 1, 8 pulses, MOSI sequence 1,0,0,0,0,0,0,1.
- FIFO_DEPTH=4, EN=0: 5 TXDATA writes → TX level 4, TX_OVF=1; write 0x40 to STATUS → TX_OVF=0.
- Run 5 bytes with no RX reads → RX level 4, RX_OVF=1, 5th byte lost; RXDATA read when empty → returns 0.
- SS=0x05, SS_ACTIVE_HIGH=0 → SPI_SS_o=0xFA; set SS_ACTIVE_HIGH → 0x05. Assert HRESETn=0 mid-byte → next cycle SCLK=0, SPI_SS_o all 1, levels 0.
- With AHB_SPI_IRQ_EN, IRQ_MASK=0x1: after a byte completes → IRQ_O rises one cycle after the RX push and falls one cycle after the last pop.

Source files
------------

// File: rtl/ahb_spi_fifo_master_pkg.sv
// Shared definitions for the AHB SPI FIFO master: register map, bit indices, engine states.
package ahb_spi_fifo_master_pkg;

    // Register offsets (HADDR[7:0])
    localparam logic [7:0] AddrCtrl    = 8'h00;
    localparam logic [7:0] AddrStatus  = 8'h04;
    localparam logic [7:0] AddrSs      = 8'h08;
    localparam logic [7:0] AddrTxData  = 8'h0C;
    localparam logic [7:0] AddrRxData  = 8'h10;
    localparam logic [7:0] AddrIrqMask = 8'h14;

    // CTRL bit indices
    localparam int unsigned CtrlEn     = 0;
    localparam int unsigned CtrlCpol   = 1;
    localparam int unsigned CtrlCpha   = 2;
    localparam int unsigned CtrlSsHigh = 3;
    localparam int unsigned CtrlDivLsb = 8;

    // STATUS bit indices
    localparam int unsigned StatBusy    = 0;
    localparam int unsigned StatTxFull  = 1;
    localparam int unsigned StatTxEmpty = 2;
    localparam int unsigned StatRxFull  = 3;
    localparam int unsigned StatRxEmpty = 4;
    localparam int unsigned StatRxOvf   = 5;
    localparam int unsigned StatTxOvf   = 6;

    // IRQ source indices
    localparam int unsigned IrqRxNotEmpty = 0;
    localparam int unsigned IrqTxEmpty    = 1;
    localparam int unsigned IrqRxOvf      = 2;
    localparam int unsigned IrqTxOvf      = 3;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI byte engine: FSM, SCLK divider, MSB-first shift registers, CPOL/CPHA handling.
// Pops one TX byte in LOAD and pushes the received byte in DONE.
module spi_shift_engine
    import ahb_spi_fifo_master_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic [DIV_WIDTH-1:0] clkdiv_i,
    input  logic                 tx_empty_i,
    input  logic [7:0]           tx_data_i,
    input  logic                 miso_i,
    output logic                 tx_pop_o,
    output logic                 rx_push_o,
    output logic [7:0]           rx_data_o,
    output logic                 active_o,
    output logic                 sclk_o,
    output logic                 mosi_o
);

    spi_state_e           state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d, clkdiv_q, clkdiv_d;
    logic [3:0]           half_q, half_d;
    logic                 cpol_q, cpol_d, cpha_q, cpha_d;
    logic [7:0]           tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic                 sclk_q, sclk_d, mosi_q, mosi_d;
    logic                 sample;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            div_q    <= '0;
            clkdiv_q <= '0;
            half_q   <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            tx_sr_q  <= '0;
            rx_sr_q  <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            clkdiv_q <= clkdiv_d;
            half_q   <= half_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            tx_sr_q  <= tx_sr_d;
            rx_sr_q  <= rx_sr_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
        end
    end

    // Next-state, divider and edge actions
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        clkdiv_d  = clkdiv_q;
        half_d    = half_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        tx_pop_o  = 1'b0;
        rx_push_o = 1'b0;
        // Even half index ends on a leading edge; CPHA flips which edge samples.
        sample    = ~half_q[0] ^ cpha_q;
        unique case (state_q)
            StIdle: begin
                sclk_d = cpol_i;
                if (en_i && !tx_empty_i) state_d = StLoad;
            end
            StLoad: begin
                tx_pop_o = 1'b1;
                cpol_d   = cpol_i;
                cpha_d   = cpha_i;
                clkdiv_d = clkdiv_i;
                sclk_d   = cpol_i;
                div_d    = '0;
                half_d   = '0;
                if (!cpha_i) begin
                    mosi_d  = tx_data_i[7];
                    tx_sr_d = {tx_data_i[6:0], 1'b0};
                end else begin
                    tx_sr_d = tx_data_i;
                end
                state_d = StShift;
            end
            StShift: begin
                if (div_q == clkdiv_q) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    half_d = half_q + 4'd1;
                    if (sample) begin
                        rx_sr_d = {rx_sr_q[6:0], miso_i};
                    end else begin
                        mosi_d  = tx_sr_q[7];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                    if (half_q == 4'd15) state_d = StDone;
                end else begin
                    div_d = div_q + DIV_WIDTH'(1);
                end
            end
            StDone: begin
                rx_push_o = 1'b1;
                state_d   = (en_i && !tx_empty_i) ? StLoad : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_data_o = rx_sr_q;
    assign active_o  = (state_q != StIdle);
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;

endmodule

// File: rtl/ahb_spi_fifo_master.sv
// AHB-Lite SPI master with TX/RX byte FIFOs, programmable SCLK divider and SS vector.
// Optional interrupt output and IRQ_MASK register when AHB_SPI_IRQ_EN is defined.
module ahb_spi_fifo_master
    import ahb_spi_fifo_master_pkg::*;
#(
    parameter int unsigned SS_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 8
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic                HREADY,
    input  logic                HWRITE,
    input  logic [31:0]         HADDR,
    input  logic [2:0]          HSIZE,
    input  logic [1:0]          HTRANS,
    input  logic [31:0]         HWDATA,
    output logic [31:0]         HRDATA,
    output logic                HREADYOUT,
    input  logic                SPI_MISO_i,
    output logic                SPI_MOSI_o,
    output logic                SPI_CLK_o,
    output logic [SS_WIDTH-1:0] SPI_SS_o
`ifdef AHB_SPI_IRQ_EN
    ,
    output logic                IRQ_o
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [7:0]           addr_q;
    logic                 wr_q, rd_q;
    logic                 en_q, cpol_q, cpha_q, ssh_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [SS_WIDTH-1:0]  ss_q;
    logic                 tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic [PW-1:0]        tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PW-1:0]        rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [7:0]           tx_mem_q [FIFO_DEPTH];
    logic [7:0]           rx_mem_q [FIFO_DEPTH];
    logic [PW-1:0]        tx_level, rx_level;
    logic                 tx_empty, tx_full, rx_empty, rx_full;
    logic                 tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
    logic                 eng_tx_pop, eng_rx_push, eng_active, busy;
    logic [7:0]           eng_rx_data;
    logic [31:0]          rdata;
    logic                 unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:8], HTRANS[0], HWDATA};

    assign tx_level = tx_wptr_q - tx_rptr_q;
    assign rx_level = rx_wptr_q - rx_rptr_q;
    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign tx_full  = (tx_wptr_q[PW-1] != tx_rptr_q[PW-1]) &&
                      (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign rx_full  = (rx_wptr_q[PW-1] != rx_rptr_q[PW-1]) &&
                      (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

    assign tx_push_req = wr_q && (addr_q == AddrTxData);
    assign tx_push     = tx_push_req && !tx_full;
    assign tx_pop      = eng_tx_pop && !tx_empty;
    assign rx_push     = eng_rx_push && !rx_full;
    assign rx_pop      = rd_q && (addr_q == AddrRxData) && !rx_empty;
    assign busy        = eng_active || (en_q && !tx_empty);

    // FIFO pointers and sticky overflow flags; a set in the same cycle beats a W1C clear
    always_comb begin
        tx_wptr_d = tx_wptr_q + PW'(tx_push);
        tx_rptr_d = tx_rptr_q + PW'(tx_pop);
        rx_wptr_d = rx_wptr_q + PW'(rx_push);
        rx_rptr_d = rx_rptr_q + PW'(rx_pop);
        tx_ovf_d  = tx_ovf_q;
        rx_ovf_d  = rx_ovf_q;
        if (wr_q && (addr_q == AddrStatus)) begin
            if (HWDATA[StatTxOvf]) tx_ovf_d = 1'b0;
            if (HWDATA[StatRxOvf]) rx_ovf_d = 1'b0;
        end
        if (tx_push_req && tx_full) tx_ovf_d = 1'b1;
        if (eng_rx_push && rx_full) rx_ovf_d = 1'b1;
    end

    // Address phase capture, control registers and FIFO state
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            addr_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            en_q      <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            ssh_q     <= 1'b0;
            div_q     <= '0;
            ss_q      <= '0;
            tx_ovf_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            addr_q    <= HREADY ? HADDR[7:0] : addr_q;
            wr_q      <= HREADY && HSEL && HTRANS[1] && HWRITE;
            rd_q      <= HREADY && HSEL && HTRANS[1] && !HWRITE;
            tx_ovf_q  <= tx_ovf_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            if (wr_q && (addr_q == AddrCtrl)) begin
                en_q   <= HWDATA[CtrlEn];
                cpol_q <= HWDATA[CtrlCpol];
                cpha_q <= HWDATA[CtrlCpha];
                ssh_q  <= HWDATA[CtrlSsHigh];
                div_q  <= HWDATA[CtrlDivLsb +: DIV_WIDTH];
            end
            if (wr_q && (addr_q == AddrSs)) ss_q <= HWDATA[SS_WIDTH-1:0];
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge HCLK) begin
        if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= HWDATA[7:0];
        if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= eng_rx_data;
    end

`ifdef AHB_SPI_IRQ_EN
    logic [3:0] irq_mask_q, irq_src;
    logic       irq_q;

    assign irq_src[IrqRxNotEmpty] = !rx_empty;
    assign irq_src[IrqTxEmpty]    = tx_empty;
    assign irq_src[IrqRxOvf]      = rx_ovf_q;
    assign irq_src[IrqTxOvf]      = tx_ovf_q;

    // Interrupt mask register and registered interrupt output
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_q && (addr_q == AddrIrqMask)) irq_mask_q <= HWDATA[3:0];
            irq_q <= |(irq_mask_q & irq_src);
        end
    end

    assign IRQ_o = irq_q;
`endif

    // Read data mux for the data phase
    always_comb begin
        rdata = '0;
        if (rd_q) begin
            case (addr_q)
                AddrCtrl: begin
                    rdata[CtrlEn]                  = en_q;
                    rdata[CtrlCpol]                = cpol_q;
                    rdata[CtrlCpha]                = cpha_q;
                    rdata[CtrlSsHigh]              = ssh_q;
                    rdata[CtrlDivLsb +: DIV_WIDTH] = div_q;
                end
                AddrStatus: begin
                    rdata[StatBusy]    = busy;
                    rdata[StatTxFull]  = tx_full;
                    rdata[StatTxEmpty] = tx_empty;
                    rdata[StatRxFull]  = rx_full;
                    rdata[StatRxEmpty] = rx_empty;
                    rdata[StatRxOvf]   = rx_ovf_q;
                    rdata[StatTxOvf]   = tx_ovf_q;
                    rdata[15:8]        = 8'(tx_level);
                    rdata[23:16]       = 8'(rx_level);
                end
                AddrSs: rdata = 32'(ss_q);
                AddrRxData: begin
                    if (!rx_empty) rdata[7:0] = rx_mem_q[rx_rptr_q[AW-1:0]];
                end
`ifdef AHB_SPI_IRQ_EN
                AddrIrqMask: rdata[3:0] = irq_mask_q;
`endif
                default: rdata = '0;
            endcase
        end
    end

    assign HRDATA    = rdata;
    assign HREADYOUT = 1'b1;
    assign SPI_SS_o  = ssh_q ? ss_q : ~ss_q;

    spi_shift_engine #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_engine (
        .clk_i     (HCLK),
        .rst_ni    (HRESETn),
        .en_i      (en_q),
        .cpol_i    (cpol_q),
        .cpha_i    (cpha_q),
        .clkdiv_i  (div_q),
        .tx_empty_i(tx_empty),
        .tx_data_i (tx_mem_q[tx_rptr_q[AW-1:0]]),
        .miso_i    (SPI_MISO_i),
        .tx_pop_o  (eng_tx_pop),
        .rx_push_o (eng_rx_push),
        .rx_data_o (eng_rx_data),
        .active_o  (eng_active),
        .sclk_o    (SPI_CLK_o),
        .mosi_o    (SPI_MOSI_o)
    );

endmodule

// File: tb/tb_ahb_spi_fifo_master.sv
// Self-checking bench for ahb_spi_fifo_master (FIFO_DEPTH=4, MISO looped back to MOSI).
// The IRQ scenario is built only when AHB_SPI_IRQ_EN is defined.
module tb_ahb_spi_fifo_master;

    localparam int unsigned Depth = 4;

    logic        HCLK, HRESETn, HSEL, HREADY, HWRITE;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HREADYOUT, miso, mosi, sclk;
    logic [7:0]  ss;
`ifdef AHB_SPI_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int model_rx_cnt = 0;
    logic exp_rx_ovf = 1'b0;

    assign miso = mosi;

    ahb_spi_fifo_master #(
        .SS_WIDTH  (8),
        .FIFO_DEPTH(Depth),
        .DIV_WIDTH (8)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HWRITE    (HWRITE),
        .HADDR     (HADDR),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .SPI_MISO_i(miso),
        .SPI_MOSI_o(mosi),
        .SPI_CLK_o (sclk),
        .SPI_SS_o  (ss)
`ifdef AHB_SPI_IRQ_EN
        ,
        .IRQ_o     (irq)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        HADDR = addr; HWRITE = 1'b1; HSEL = 1'b1; HTRANS = 2'b10;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        HADDR = addr; HWRITE = 1'b0; HSEL = 1'b1; HTRANS = 2'b10;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
        @(posedge HCLK); #1;
    endtask

    // Push a byte that will be transmitted; the model predicts whether RX keeps it.
    task automatic push_tx(input logic [7:0] b);
        ahb_write(32'h0C, {24'h0, b});
        if (model_rx_cnt < Depth) begin
            exp_q.push_back(b);
            model_rx_cnt++;
        end else begin
            exp_rx_ovf = 1'b1;
        end
    endtask

    task automatic pop_rx_check(input string name);
        logic [31:0] d;
        logic [31:0] e;
        e = {24'h0, exp_q.pop_front()};
        model_rx_cnt--;
        ahb_read(32'h10, d);
        checks++;
        if (d !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, d, e);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] addrs [5];
        logic [31:0] exps [5];
        addrs = '{32'h00, 32'h04, 32'h08, 32'h14, 32'h20};
        exps  = '{32'h0, 32'h14, 32'h0, 32'h0, 32'h0};
        checks++;
        if (HRDATA !== 32'h0) begin
            failures++; $display("FAIL reset_hrdata: got %h expected 0", HRDATA);
        end
        checks++;
        if (ss !== 8'hFF) begin
            failures++; $display("FAIL reset_ss: got %h expected ff", ss);
        end
        checks++;
        if ({sclk, mosi, HREADYOUT} !== 3'b001) begin
            failures++;
            $display("FAIL reset_pins: got sclk,mosi,hreadyout=%b expected 001",
                     {sclk, mosi, HREADYOUT});
        end
`ifdef AHB_SPI_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL reset_irq: got %b expected 0", irq);
        end
`endif
        for (int i = 0; i < 5; i++) begin
            ahb_read(addrs[i], d);
            checks++;
            if (d !== exps[i]) begin
                failures++;
                $display("FAIL reset_read_%h: got %h expected %h", addrs[i], d, exps[i]);
            end
        end
    endtask

    task automatic test_mode0();
        int e;
        int rises[$];
        logic prev;
        ahb_write(32'h00, 32'h0000_0101);
        push_tx(8'hA5);
        e = cyc;
        push_tx(8'h3C);
        prev = sclk;
        for (int i = 0; i < 120; i++) begin
            @(posedge HCLK); #1;
            if (!prev && sclk) rises.push_back(cyc - e);
            prev = sclk;
        end
        checks++;
        if (rises.size() != 16) begin
            failures++; $display("FAIL mode0_pulses: got %0d expected 16", rises.size());
        end
        checks++;
        if (rises.size() >= 9) begin
            if (rises[0] != 4) begin
                failures++; $display("FAIL mode0_latency: got %0d expected 4", rises[0]);
            end
            checks++;
            if (rises[8] - rises[0] != 34) begin
                failures++;
                $display("FAIL mode0_byte_time: got %0d expected 34", rises[8] - rises[0]);
            end
        end else begin
            failures++; $display("FAIL mode0_rises: got %0d expected >=9", rises.size());
        end
        checks++;
        if (sclk !== 1'b0) begin
            failures++; $display("FAIL mode0_idle_sclk: got %b expected 0", sclk);
        end
        pop_rx_check("mode0_rx0");
        pop_rx_check("mode0_rx1");
    endtask

    task automatic test_mode3();
        logic prev;
        logic [7:0] bits;
        int nbits;
        int falls;
        nbits = 0; falls = 0; bits = '0;
        ahb_write(32'h00, 32'h0000_0007);
        @(posedge HCLK); #1;
        checks++;
        if (sclk !== 1'b1) begin
            failures++; $display("FAIL mode3_idle_sclk: got %b expected 1", sclk);
        end
        push_tx(8'h81);
        prev = sclk;
        for (int i = 0; i < 40; i++) begin
            @(posedge HCLK); #1;
            if (!prev && sclk) begin
                bits = {bits[6:0], mosi};
                nbits++;
            end
            if (prev && !sclk) falls++;
            prev = sclk;
        end
        checks++;
        if (falls != 8 || nbits != 8) begin
            failures++;
            $display("FAIL mode3_pulses: got falls=%0d rises=%0d expected 8,8", falls, nbits);
        end
        checks++;
        if (bits !== 8'h81) begin
            failures++; $display("FAIL mode3_mosi: got %b expected 10000001", bits);
        end
        checks++;
        if (sclk !== 1'b1) begin
            failures++; $display("FAIL mode3_end_sclk: got %b expected 1", sclk);
        end
        pop_rx_check("mode3_rx");
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        ahb_write(32'h00, 32'h0);
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        push_tx(8'h44);
        ahb_write(32'h0C, 32'h99);
        ahb_read(32'h04, d);
        checks++;
        if (d !== 32'h0000_0452) begin
            failures++; $display("FAIL txovf_status: got %h expected 00000452", d);
        end
        ahb_write(32'h04, 32'h40);
        ahb_read(32'h04, d);
        checks++;
        if (d !== 32'h0000_0412) begin
            failures++; $display("FAIL txovf_clear: got %h expected 00000412", d);
        end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] d;
        logic [31:0] e;
        int polls;
        ahb_write(32'h00, 32'h0000_0001);
        repeat (4) @(posedge HCLK);
        #1;
        push_tx(8'h55);
        polls = 0;
        d = 32'h1;
        while (d[0] && polls < 100) begin
            ahb_read(32'h04, d);
            polls++;
        end
        checks++;
        if (d[0] !== 1'b0) begin
            failures++; $display("FAIL rxovf_busy_timeout: got busy=%b expected 0", d[0]);
        end
        e = (32'(model_rx_cnt) << 16) | 32'h0C | (32'(exp_rx_ovf) << 5);
        checks++;
        if (d !== e) begin
            failures++; $display("FAIL rxovf_status: got %h expected %h", d, e);
        end
        for (int i = 0; i < 4; i++) pop_rx_check("rxovf_data");
        ahb_read(32'h10, d);
        checks++;
        if (d !== 32'h0) begin
            failures++; $display("FAIL rx_empty_read: got %h expected 0", d);
        end
        ahb_read(32'h04, d);
        checks++;
        if (d !== 32'h34) begin
            failures++; $display("FAIL rxovf_sticky: got %h expected 00000034", d);
        end
        ahb_write(32'h04, 32'h20);
        exp_rx_ovf = 1'b0;
        ahb_read(32'h04, d);
        checks++;
        if (d !== 32'h14) begin
            failures++; $display("FAIL rxovf_clear: got %h expected 00000014", d);
        end
    endtask

    task automatic test_ss_and_reset();
        logic [31:0] d;
        ahb_write(32'h08, 32'h05);
        checks++;
        if (ss !== 8'hFA) begin
            failures++; $display("FAIL ss_low: got %h expected fa", ss);
        end
        ahb_read(32'h08, d);
        checks++;
        if (d !== 32'h05) begin
            failures++; $display("FAIL ss_read: got %h expected 5", d);
        end
        ahb_write(32'h00, 32'h08);
        checks++;
        if (ss !== 8'h05) begin
            failures++; $display("FAIL ss_high: got %h expected 05", ss);
        end
        ahb_write(32'h00, 32'h0000_0109);
        ahb_write(32'h0C, 32'hFF);
        repeat (10) @(posedge HCLK);
        #1;
        checks++;
        if (mosi !== 1'b1) begin
            failures++; $display("FAIL midbyte_mosi: got %b expected 1", mosi);
        end
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        checks++;
        if ({sclk, mosi, ss} !== {2'b00, 8'hFF}) begin
            failures++;
            $display("FAIL midreset_pins: got sclk=%b mosi=%b ss=%h expected 0,0,ff",
                     sclk, mosi, ss);
        end
        checks++;
        if (HRDATA !== 32'h0) begin
            failures++; $display("FAIL midreset_hrdata: got %h expected 0", HRDATA);
        end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        exp_q.delete();
        model_rx_cnt = 0;
        exp_rx_ovf = 1'b0;
        ahb_read(32'h04, d);
        checks++;
        if (d !== 32'h14) begin
            failures++; $display("FAIL midreset_status: got %h expected 00000014", d);
        end
        ahb_read(32'h00, d);
        checks++;
        if (d !== 32'h0) begin
            failures++; $display("FAIL midreset_ctrl: got %h expected 0", d);
        end
    endtask

`ifdef AHB_SPI_IRQ_EN
    task automatic test_irq();
        logic [31:0] d;
        int waited;
        ahb_write(32'h14, 32'h1);
        ahb_read(32'h14, d);
        checks++;
        if (d !== 32'h1) begin
            failures++; $display("FAIL irq_mask_read: got %h expected 1", d);
        end
        ahb_write(32'h00, 32'h0000_0001);
        push_tx(8'h5A);
        waited = 0;
        while (irq !== 1'b1 && waited < 100) begin
            @(posedge HCLK); #1;
            waited++;
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL irq_rise: got %b expected 1", irq);
        end
        pop_rx_check("irq_rx");
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL irq_lag: got %b expected 1", irq);
        end
        @(posedge HCLK); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_fall: got %b expected 0", irq);
        end
    endtask
`endif

    initial begin
        HRESETn = 1'b0;
        HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0;
        HADDR = '0; HWDATA = '0; HSIZE = 3'b010; HTRANS = 2'b00;
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        test_reset();
        test_mode0();
        test_mode3();
        test_tx_overflow();
        test_rx_overflow();
        test_ss_and_reset();
`ifdef AHB_SPI_IRQ_EN
        test_irq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
